// File: rtl/jk_latch_driver.sv
// ---------------------------------------------------------------------------
// jk_latch_driver
//
// Purpose:
//   Command-side driver for a bank of gated JK latches. A target vector is
//   accepted over a valid/ready handshake. J/K excitation is derived from the
//   latch outputs seen at acceptance. The shared latch enable is then pulsed
//   for PULSE_CYCLES, followed by SETTLE_CYCLES of quiet time. The latch rails
//   are read back and a pass/mismatch response is returned over a second
//   valid/ready handshake.
//
// Optional feature:
//   JK_DRIVER_READBACK_EN - when defined, a CHECK state samples latchOut and
//   latchNotout and builds the response from them. When undefined, CHECK is
//   skipped, the response is always ok with no mismatches, and latchNotout is
//   ignored.
//
// Ports:
//   clock          single clock, rising edge
//   reset          synchronous, active-high
//   reqValid       request present
//   reqTarget      desired latch state [WIDTH]
//   reqReady       driver can accept a request (IDLE only)
//   enable         latch-bank enable, shared by all bits
//   jack / kilby   per-bit J / K excitation [WIDTH]
//   latchOut       latch out rails [WIDTH]
//   latchNotout    latch notout rails [WIDTH]
//   respValid      response present (DONE)
//   respOk         all bits match and the rails are complementary
//   respMismatch   per-bit failure flags [WIDTH]
//   respReady      consumer takes the response
// ---------------------------------------------------------------------------
module jk_latch_driver #(
  parameter int WIDTH         = 4,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reqValid,
  input  logic [WIDTH-1:0] reqTarget,
  output logic             reqReady,
  output logic             enable,
  output logic [WIDTH-1:0] jack,
  output logic [WIDTH-1:0] kilby,
  input  logic [WIDTH-1:0] latchOut,
  input  logic [WIDTH-1:0] latchNotout,
  output logic             respValid,
  output logic             respOk,
  output logic [WIDTH-1:0] respMismatch,
  input  logic             respReady
);

  localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counters count down to zero; the load value is "cycles in state" - 1.
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

`ifdef JK_DRIVER_READBACK_EN
  localparam logic [2:0] ST_AFTER_SETTLE = ST_CHECK;
`else
  localparam logic [2:0] ST_AFTER_SETTLE = ST_DONE;
`endif
  // A zero-length settle phase is skipped entirely.
  localparam logic [2:0] ST_AFTER_DRIVE = (SETTLE_CYCLES == 0) ? ST_AFTER_SETTLE : ST_SETTLE;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q;
  logic             en_q;
  logic [WIDTH-1:0] jack_q, kilby_q;
  logic             vld_q;
  logic             ok_q;
  logic [WIDTH-1:0] mism_q;
  logic             accept;

  // reqReady is registered so it stays low through the reset edge and only
  // rises on the first edge where reset is seen low.
  assign accept = (state_q == ST_IDLE) & rdy_q & reqValid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DRIVE;
          cnt_d   = PULSE_LOAD;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_AFTER_DRIVE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_AFTER_SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef JK_DRIVER_READBACK_EN
      ST_CHECK: begin
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (respReady) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef JK_DRIVER_READBACK_EN
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] mism_check;

  // A bit fails if it missed its target or its two rails agree.
  assign mism_check = (latchOut ^ target_q) | ~(latchOut ^ latchNotout);
`else
  logic unused_notout;
  assign unused_notout = ^latchNotout;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      en_q    <= 1'b0;
      jack_q  <= '0;
      kilby_q <= '0;
      vld_q   <= 1'b0;
      ok_q    <= 1'b0;
      mism_q  <= '0;
`ifdef JK_DRIVER_READBACK_EN
      target_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == ST_IDLE);
      en_q    <= (state_d == ST_DRIVE);
      vld_q   <= (state_d == ST_DONE);

      // Excitation: set bits that are low but wanted high, reset bits that
      // are high but wanted low. J=K=1 cannot arise from these two terms.
      if (accept) begin
        jack_q  <= reqTarget & ~latchOut;
        kilby_q <= ~reqTarget & latchOut;
      end else if (state_d != ST_DRIVE) begin
        jack_q  <= '0;
        kilby_q <= '0;
      end

`ifdef JK_DRIVER_READBACK_EN
      if (accept) begin
        target_q <= reqTarget;
      end
      if (state_q == ST_CHECK) begin
        mism_q <= mism_check;
        ok_q   <= ~|mism_check;
      end
`else
      if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
        mism_q <= '0;
        ok_q   <= 1'b1;
      end
`endif
    end
  end

  assign reqReady     = rdy_q;
  assign enable       = en_q;
  assign jack         = jack_q;
  assign kilby        = kilby_q;
  assign respValid    = vld_q;
  assign respOk       = ok_q;
  assign respMismatch = mism_q;

endmodule

// File: tb/tb_jk_latch_driver.sv
// ---------------------------------------------------------------------------
// tb_jk_latch_driver
//
// Drives jk_latch_driver (default parameters) against a behavioural gated JK
// latch bank with injectable faults (stuck-at-0 bits, notout rail equal to
// out). Expected excitation, timing and response are derived per transaction
// from the request and the latch state at acceptance. The readback build is
// selected with JK_DRIVER_READBACK_EN, exactly as for the design.
// ---------------------------------------------------------------------------
module tb_jk_latch_driver;

  localparam int W = 4;
  localparam int P = 2;
  localparam int S = 1;
`ifdef JK_DRIVER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  // Cycle (counted from the acceptance edge) in which respValid first shows.
  localparam int RESP_K = RB ? (P + S + 2) : (P + S + 1);

  logic         clock = 1'b0;
  logic         reset;
  logic         reqValid;
  logic [W-1:0] reqTarget;
  logic         reqReady;
  logic         enable;
  logic [W-1:0] jack;
  logic [W-1:0] kilby;
  logic [W-1:0] latchOut;
  logic [W-1:0] latchNotout;
  logic         respValid;
  logic         respOk;
  logic [W-1:0] respMismatch;
  logic         respReady;

  // Latch bank model and fault controls
  logic [W-1:0] lat;
  logic         preset_en;
  logic [W-1:0] preset_val;
  logic [W-1:0] stuck0_mask;
  logic [W-1:0] notout_eq_mask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  jk_latch_driver #(
    .WIDTH        (W),
    .PULSE_CYCLES (P),
    .SETTLE_CYCLES(S)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .reqValid    (reqValid),
    .reqTarget   (reqTarget),
    .reqReady    (reqReady),
    .enable      (enable),
    .jack        (jack),
    .kilby       (kilby),
    .latchOut    (latchOut),
    .latchNotout (latchNotout),
    .respValid   (respValid),
    .respOk      (respOk),
    .respMismatch(respMismatch),
    .respReady   (respReady)
  );

  // Gated JK latch: while enabled, J sets, K resets, both toggles.
  always @(posedge clock) begin
    if (preset_en) begin
      lat <= preset_val;
    end else if (enable) begin
      for (int i = 0; i < W; i++) begin
        case ({jack[i], kilby[i]})
          2'b10:   lat[i] <= 1'b1;
          2'b01:   lat[i] <= 1'b0;
          2'b11:   lat[i] <= ~lat[i];
          default: lat[i] <= lat[i];
        endcase
      end
    end
  end

  assign latchOut    = lat & ~stuck0_mask;
  assign latchNotout = (~latchOut & ~notout_eq_mask) | (latchOut & notout_eq_mask);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preset_latch(input logic [W-1:0] v);
    @(negedge clock);
    preset_val = v;
    preset_en  = 1'b1;
    @(negedge clock);
    preset_en  = 1'b0;
  endtask

  // One full request/response. hold = cycles respReady stays low once the
  // response is valid (0: respReady already high on DONE entry). noise keeps
  // reqValid asserted with a junk target while the driver is busy.
  task automatic run_txn(input string name, input logic [W-1:0] target,
                         input int hold, input bit noise);
    logic [W-1:0] out0, exp_j, exp_k, exp_out, exp_mism;
    logic         exp_ok;
    int           waited;
    waited = 0;
    while (reqReady !== 1'b1 && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    check_val({name, "_ready_idle"}, 32'(reqReady), 32'd1);

    respReady = (hold == 0);
    reqValid  = 1'b1;
    reqTarget = target;
    out0      = latchOut;
    exp_j     = target & ~out0;
    exp_k     = ~target & out0;
    // A healthy latch reaches the target; stuck bits read back as 0.
    exp_out   = target & ~stuck0_mask;
    exp_mism  = RB ? ((exp_out ^ target) | notout_eq_mask) : '0;
    exp_ok    = (exp_mism == '0);

    @(posedge clock);  // acceptance edge n
    for (int k = 1; k <= RESP_K; k++) begin
      @(negedge clock);
      if (k == 1) begin
        if (noise) reqTarget = W'($urandom);
        else       reqValid  = 1'b0;
      end
      check_val({name, "_enable"},    32'(enable),    32'(k <= P));
      check_val({name, "_jack"},      32'(jack),      (k <= P) ? 32'(exp_j) : 32'd0);
      check_val({name, "_kilby"},     32'(kilby),     (k <= P) ? 32'(exp_k) : 32'd0);
      check_val({name, "_busy_rdy"},  32'(reqReady),  32'd0);
      check_val({name, "_respValid"}, 32'(respValid), 32'(k == RESP_K));
    end
    reqValid = 1'b0;
    check_val({name, "_respOk"},   32'(respOk),       32'(exp_ok));
    check_val({name, "_mismatch"}, 32'(respMismatch), 32'(exp_mism));

    for (int h = 1; h < hold; h++) begin
      @(negedge clock);
      check_val({name, "_hold_valid"}, 32'(respValid),    32'd1);
      check_val({name, "_hold_ok"},    32'(respOk),       32'(exp_ok));
      check_val({name, "_hold_mism"},  32'(respMismatch), 32'(exp_mism));
      check_val({name, "_hold_rdy"},   32'(reqReady),     32'd0);
    end
    respReady = 1'b1;
    @(negedge clock);
    check_val({name, "_post_valid"}, 32'(respValid), 32'd0);
    check_val({name, "_post_rdy"},   32'(reqReady),  32'd1);
    check_val({name, "_final_latch"}, 32'(latchOut), 32'(exp_out));
    respReady = 1'b0;
    $display("txn %s target=%b j=%b k=%b hold=%0d ok=%0b mism=%b latch=%b",
             name, target, exp_j, exp_k, hold, respOk, respMismatch, latchOut);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    reqValid       = 1'b0;
    reqTarget      = '0;
    respReady      = 1'b0;
    preset_en      = 1'b1;
    preset_val     = '0;
    stuck0_mask    = '0;
    notout_eq_mask = '0;

    repeat (3) @(negedge clock);
    check_val("rst_reqReady",  32'(reqReady),     32'd0);
    check_val("rst_enable",    32'(enable),       32'd0);
    check_val("rst_jack",      32'(jack),         32'd0);
    check_val("rst_kilby",     32'(kilby),        32'd0);
    check_val("rst_respValid", 32'(respValid),    32'd0);
    check_val("rst_respOk",    32'(respOk),       32'd0);
    check_val("rst_mismatch",  32'(respMismatch), 32'd0);
    reset     = 1'b0;
    preset_en = 1'b0;
    @(negedge clock);
    check_val("rst_release_rdy", 32'(reqReady), 32'd1);

    // Directed scenarios
    preset_latch(4'b0000);
    run_txn("set_from_zero", 4'b1011, 0, 1'b0);
    preset_latch(4'b1100);
    run_txn("mixed", 4'b0110, 1, 1'b0);
    preset_latch(4'b0101);
    run_txn("no_change_bp", 4'b0101, 3, 1'b1);

    preset_latch(4'b0000);
    stuck0_mask = 4'b0100;
    run_txn("stuck_bit2", 4'b0100, 1, 1'b0);
    stuck0_mask = 4'b0000;

    preset_latch(4'b0000);
    notout_eq_mask = 4'b0001;
    run_txn("notout_eq0", 4'b0011, 2, 1'b0);
    notout_eq_mask = 4'b0000;

    // Reset one cycle after acceptance
    preset_latch(4'b0000);
    reqValid  = 1'b1;
    reqTarget = 4'b1111;
    @(posedge clock);
    @(negedge clock);
    reqValid = 1'b0;
    check_val("mid_rst_enable_before", 32'(enable), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_val("mid_rst_enable", 32'(enable),    32'd0);
    check_val("mid_rst_jack",   32'(jack),      32'd0);
    check_val("mid_rst_kilby",  32'(kilby),     32'd0);
    check_val("mid_rst_rdy",    32'(reqReady),  32'd0);
    check_val("mid_rst_valid",  32'(respValid), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_val("mid_rst_release_rdy", 32'(reqReady), 32'd1);
    for (int c = 0; c < 8; c++) begin
      check_val("mid_rst_no_resp", 32'(respValid), 32'd0);
      @(negedge clock);
    end
    $display("txn mid_drive_reset target=1111 enable=%b rdy=%b", enable, reqReady);

    // Randomized traffic, with occasional random latch preloads
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) preset_latch(W'($urandom));
      run_txn($sformatf("rand%0d", t), W'($urandom), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
